// File: rtl/cdb_result_arbiter.sv
// Round-robin arbiter that shares LANES common-data-bus lanes among FU_NUM
// functional units and registers the winners' results onto the lanes.
module cdb_result_arbiter #(
    parameter int unsigned FU_NUM    = 8,
    parameter int unsigned FU_INDEX  = 3,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned RB_INDEX  = 4,
    parameter int unsigned LANES     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FU_NUM-1:0]             req,
    input  logic [FU_NUM*WORD_SIZE-1:0]   req_data,
    input  logic [FU_NUM*RB_INDEX-1:0]    req_rb_index,
    input  logic                          stall,
    input  logic                          flush,
    output logic [FU_NUM-1:0]             grant,
    output logic [LANES-1:0]              cdb_valid,
    output logic [LANES*WORD_SIZE-1:0]    cdb_data,
    output logic [LANES*RB_INDEX-1:0]     cdb_rb_index,
    output logic [LANES*FU_INDEX-1:0]     cdb_fu,
    output logic [FU_INDEX-1:0]           rr_ptr
);

    localparam logic [FU_INDEX:0] FU_NUM_W = (FU_INDEX+1)'(FU_NUM);
    localparam logic [FU_INDEX:0] ONE_W    = (FU_INDEX+1)'(1);

    logic [WORD_SIZE-1:0] data_a [FU_NUM];
    logic [RB_INDEX-1:0]  rb_a   [FU_NUM];

    logic [LANES-1:0]     cdb_valid_q;
    logic [WORD_SIZE-1:0] lane_data_q [LANES];
    logic [RB_INDEX-1:0]  lane_rb_q   [LANES];
    logic [FU_INDEX-1:0]  lane_fu_q   [LANES];
    logic [FU_INDEX-1:0]  rr_ptr_q, rr_ptr_d;

    logic [FU_NUM-1:0]    grant_c;
    logic [LANES-1:0]     lane_vld_d;
    logic [FU_INDEX-1:0]  lane_sel_d [LANES];
    logic [FU_INDEX:0]    pos, nxt;
    logic [FU_INDEX-1:0]  idx;
    int unsigned          seen;

    for (genvar g = 0; g < FU_NUM; g++) begin : g_unpack
        assign data_a[g] = req_data[g*WORD_SIZE +: WORD_SIZE];
        assign rb_a[g]   = req_rb_index[g*RB_INDEX +: RB_INDEX];
    end

    // Scan FUs starting at rr_ptr; the n-th requester found takes lane n.
    always_comb begin
        grant_c    = '0;
        lane_vld_d = '0;
        rr_ptr_d   = rr_ptr_q;
        seen       = 0;
        pos        = '0;
        nxt        = '0;
        idx        = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_sel_d[l] = '0;
        end
        if (reset && !stall && !flush) begin
            for (int unsigned k = 0; k < FU_NUM; k++) begin
                pos = {1'b0, rr_ptr_q} + (FU_INDEX+1)'(k);
                if (pos >= FU_NUM_W) begin
                    pos = pos - FU_NUM_W;
                end
                idx = pos[FU_INDEX-1:0];
                if (req[idx] && seen < LANES) begin
                    grant_c[idx] = 1'b1;
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (l == seen) begin
                            lane_vld_d[l] = 1'b1;
                            lane_sel_d[l] = idx;
                        end
                    end
                    nxt      = pos + ONE_W;
                    rr_ptr_d = (nxt == FU_NUM_W) ? '0 : nxt[FU_INDEX-1:0];
                    seen     = seen + 1;
                end
            end
        end
        if (flush) begin
            rr_ptr_d = '0;
        end
    end

    // Idle lanes keep their last payload; only the valid bit drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid_q <= '0;
            rr_ptr_q    <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                lane_data_q[l] <= '0;
                lane_rb_q[l]   <= '0;
                lane_fu_q[l]   <= '0;
            end
        end else begin
            cdb_valid_q <= lane_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int unsigned l = 0; l < LANES; l++) begin
                if (lane_vld_d[l]) begin
                    lane_data_q[l] <= data_a[lane_sel_d[l]];
                    lane_rb_q[l]   <= rb_a[lane_sel_d[l]];
                    lane_fu_q[l]   <= lane_sel_d[l];
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign cdb_data[g*WORD_SIZE +: WORD_SIZE]  = lane_data_q[g];
        assign cdb_rb_index[g*RB_INDEX +: RB_INDEX] = lane_rb_q[g];
        assign cdb_fu[g*FU_INDEX +: FU_INDEX]       = lane_fu_q[g];
    end

    assign grant     = grant_c;
    assign cdb_valid = cdb_valid_q;
    assign rr_ptr    = rr_ptr_q;

endmodule

// File: doc/cdb_result_arbiter.md
Name: cdb_result_arbiter

Overview:
- Shares the CDB_data broadcast lanes between all functional units (ALU, load, store and branch reservation stations) that have a finished result.
- Each cycle it grants up to LANES requesting FUs in round-robin order and registers their result, reorder-buffer index and FU id onto the lanes.
- Sits between the FU result buses and the reorder buffer and reservation-station CDB snoop ports.
- Honours a back-pressure stall from the reorder buffer and a flush on branch mispredict.

Parameters:
- FU_NUM, 8, number of requesting functional units.
- FU_INDEX, 3, width of an FU id; equals ceil(log2(FU_NUM)).
- WORD_SIZE, 32, result data width.
- RB_INDEX, 4, reorder-buffer index width.
- LANES, 2, number of CDB broadcast lanes; legal range 1..FU_NUM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  FU_NUM  bit i set = FU i holds a result.
- req_data  in  FU_NUM*WORD_SIZE  FU i result at slice [i*WORD_SIZE +: WORD_SIZE].
- req_rb_index  in  FU_NUM*RB_INDEX  FU i destination ROB entry.
- stall  in  1  ROB cannot accept broadcasts this cycle.
- flush  in  1  mispredict flush; synchronous.
- grant  out  FU_NUM  combinational; bit i = FU i result accepted at this edge.
- cdb_valid  out  LANES  lane k carries a result this cycle.
- cdb_data  out  LANES*WORD_SIZE  lane k data.
- cdb_rb_index  out  LANES*RB_INDEX  lane k ROB index.
- cdb_fu  out  LANES*FU_INDEX  lane k source FU id.
- rr_ptr  out  FU_INDEX  current highest-priority FU; exported for debug and verification.

Behaviour:
- Reset (reset=0, asynchronous): cdb_valid=0, cdb_data=0, cdb_rb_index=0, cdb_fu=0, rr_ptr=0. grant is forced to 0 while reset=0.
- Selection is combinational in cycle t:
  - Scan FUs in order rr_ptr, rr_ptr+1, … mod FU_NUM.
  - The first min(LANES, popcount(req)) requesters win.
  - grant bits are set for the winners only.
  - At most LANES grant bits are high at once.
- Lane assignment: the first winner in scan order goes to lane 0, the next to lane 1, and so on. Unused lanes have cdb_valid=0; their data, rb_index and fu fields hold the previous value.
- Latency: a result granted in cycle t appears on the lanes in cycle t+1. cdb_valid is high for exactly one cycle per grant.
- FU handshake:
  - An FU keeps req, req_data and req_rb_index stable until it sees grant high at a rising edge.
  - It may deassert req, or present a new result, from the next cycle.
  - A req held without grant is never lost.
  - Data seen at the granting edge is the data broadcast.
- Pointer update: if any grant, rr_ptr <= (index of last winner + 1) mod FU_NUM. With no grants, rr_ptr is unchanged.
- Fairness: a continuously requesting FU is granted within ceil(FU_NUM/LANES) cycles of stall-free operation.
- stall=1: grant=0, next-cycle cdb_valid=0, rr_ptr unchanged.
- flush=1:
  - grant=0.
  - At the edge: cdb_valid<=0 and rr_ptr<=0.
  - Results pending in FUs are discarded by the FUs' own flush logic, not by the arbiter.
  - flush overrides stall.
- Simultaneous stall and new requests: all requests wait, with no priority change.
- Reset asserted mid-broadcast: lanes invalid immediately, asynchronously; no partial broadcast.
- req bits above FU_NUM-1 do not exist. The arbiter does not check for duplicate rb_index values; the ROB guarantees uniqueness.

Test Plan:
1. Reset: hold reset=0 with req=8'hFF. Required: grant=0, cdb_valid=0, rr_ptr=0. Release reset; the first edge grants FU0 and FU1.
2. Single request: req=8'h08, FU3 data 32'hDEADBEEF, rb_index 5. Required: grant=8'h08 in cycle t. In cycle t+1: cdb_valid=2'b01, lane0 data=DEADBEEF, rb=5, fu=3, and rr_ptr=4.
3. Saturation, LANES=2, req=8'hFF held and each FU re-requesting immediately. Required grant sequence: 03, 0C, 30, C0, 03; every grant bit appears once per 4 cycles.
4. Wrap ordering: rr_ptr=4, req=8'h42 (FU1, FU6). Required: lane0 fu=6, lane1 fu=1, rr_ptr becomes 2.
5. Stall: req=8'h05, stall=1 for 3 cycles. Required: grant=0, cdb_valid=0 and rr_ptr unchanged throughout. Drop stall: grant=8'h05 and both lanes valid in the next cycle.
6. Flush and mid-op reset:
   - flush=1 in the cycle after a grant. Required: the granted broadcast still appears in that cycle, then cdb_valid=0 and rr_ptr=0.
   - Repeat with reset pulsed low mid-cycle. Required: cdb_valid drops without waiting for a clock edge.
